nes_dual_poller: RTL
====================

// Module: nes_dual_poller
// PURPOSE
//  Controller for the two NES gamepads that drive paddle input in VGA Pong. One
//  start strobe per frame (from the VGA timing block) starts a poll. The block
//  sequences the shared latch/clock lines of both pads' 4021 shift registers and
//  shifts out 8 bits from each pad in parallel. It then publishes two button
//  bytes atomically to the game logic.
// PARAMETERS
//  LATCH_CYC  302  latch-high length in clk cycles (12 us @ 25.175 MHz); >= 2
//  HALF_CYC   151  half-period of nes_clk in clk cycles (6 us); >= 4
// PORTS
//  clk          in   1  system clock (pixel clock domain)
//  rst_n        in   1  asynchronous, active-low reset
//  start        in   1  poll request, 1-cycle pulse; honoured only while idle
//  nes_data_p1  in   1  serial data from pad 1, active-low, asynchronous
//  nes_data_p2  in   1  serial data from pad 2, active-low, asynchronous
//  nes_latch    out  1  shared latch to both pads, active-high
//  nes_clk      out  1  shared shift clock to both pads, idle low
//  buttons_p1   out  8  pad 1 buttons, 1 = pressed
//  buttons_p2   out  8  pad 2 buttons, 1 = pressed
//  valid        out  1  1-cycle pulse: buttons_p1/p2 just updated
//  busy         out  1  high from the cycle after start is accepted until valid
// BEHAVIOUR
//  - Reset (async assert, sync release): nes_latch=0, nes_clk=0, buttons_p1/p2=0,
//    valid=0, busy=0, FSM=IDLE, synchroniser flops=1 (means released).
//  - Data inputs pass through 2-FF synchronisers before use; no other path uses raw inputs.
//  - FSM: IDLE -> LATCH -> LOW -> HIGH -> (LOW | DONE) -> IDLE.
//    IDLE:  start=1 -> LATCH, bit index=0, down-counter loaded with LATCH_CYC-1.
//    LATCH: nes_latch=1 for exactly LATCH_CYC cycles, then -> LOW.
//    LOW:   nes_clk=0 for HALF_CYC cycles. On the last cycle, shift in
//           ~sync_p1 and ~sync_p2 at bit[index]. Then -> HIGH.
//    HIGH:  nes_clk=1 for HALF_CYC cycles. Then index==7 -> DONE; else index++ and -> LOW.
//    DONE:  copy both shift regs to buttons_p1/p2 and pulse valid on the same edge.
//           busy drops on that edge; -> IDLE.
//  - Latency: start accepted at cycle N -> valid high at cycle N+1+LATCH_CYC+16*HALF_CYC.
//    With default parameters that is N+2719.
//  - Bit order: bit0=A, 1=B, 2=Select, 3=Start, 4=Up, 5=Down, 6=Left, 7=Right.
//  - Outputs nes_latch and nes_clk are registered and glitch-free. nes_latch and
//    nes_clk are never high together.
//  - buttons_p1/p2 hold their last value between polls and never show a partial update.
//  - start while busy, or in the DONE cycle, is dropped; there is no queueing.
//  - An unplugged pad reads as a pulled-up line, i.e. buttons=0x00. This is not an error.
//  - Reset mid-poll aborts immediately: lines go low, buttons clear, no valid pulse.
//  - Counter width is $clog2(max(LATCH_CYC,HALF_CYC)). The 3-bit index never wraps;
//    exit at 7 is explicit.
// STRUCTURE
//  - Shared package pong_pkg:
//    - button index constants BTN_A..BTN_RIGHT;
//    - FSM state typedef nes_state_t {IDLE, LATCH, LOW, HIGH, DONE};
//    - default timing constants NES_LATCH_CYC and NES_HALF_CYC.
//  - One sub-module nes_input_sync: 2-FF synchroniser with reset value 1, instanced
//    once per pad.
//  - The FSM, counter, index and the two shift registers live in the top block.
// TESTING (bench models two 4021 pads; use LATCH_CYC=4, HALF_CYC=4 unless stated)
//  1. Reset values: hold rst_n=0 with inputs toggling -> every output 0.
//     Release -> still 0, busy=0.
//  2. Single poll: pad1 presses A+Start, pad2 presses Up+Right, start pulse at cycle N.
//     - Required: buttons_p1=8'h09 and buttons_p2=8'h90, valid high only at cycle N+69.
//     - Required: exactly 4 latch cycles and 8 nes_clk pulses of 4 cycles high each.
//  3. Start ignored while busy: pulse start at N, then again at N+10 and at N+68.
//     Required: exactly one valid, at N+69, and busy stays high continuously.
//  4. Back-to-back polls: start at N and N+70; pad1 changes 8'hFF->8'h00 between them.
//     Required: valids at N+69 (p1=FF) and N+139 (p1=00). No intermediate value is ever seen.
//  5. Reset mid-poll: assert rst_n=0 during the 3rd HIGH phase.
//     Required: latch and nes_clk go low at once, buttons clear to 0, no valid pulse.
//     After release, a new start completes normally.
//  6. Default timing: parameters left at defaults, pads all released.
//     Required: latch high 302 cycles, nes_clk period 302 cycles, valid at N+2719,
//     buttons=0x00.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared definitions for the Pong input path: NES button bit positions, the
// pad poller's state encoding and its default line timing.
package pong_pkg;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    // 12 us latch and 6 us half-period at a 25.175 MHz pixel clock
    localparam int NES_LATCH_CYC = 302;
    localparam int NES_HALF_CYC  = 151;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LATCH = 3'd1,
        LOW   = 3'd2,
        HIGH  = 3'd3,
        DONE  = 3'd4
    } nes_state_t;

    function automatic int nes_cnt_width(input int latch_cyc, input int half_cyc);
        return $clog2((latch_cyc > half_cyc) ? latch_cyc : half_cyc);
    endfunction

endpackage

// File: rtl/nes_input_sync.sv
// Two-flop synchroniser for one pad data line. Resets to 1, which the poller
// reads as "button released".
module nes_input_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            dout <= 1'b1;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/nes_dual_poller.sv
// Polls two NES pads over shared latch/clock lines once per start strobe and
// publishes both button bytes together with a one-cycle valid pulse.
module nes_dual_poller
    import pong_pkg::*;
#(
    parameter int LATCH_CYC = NES_LATCH_CYC,
    parameter int HALF_CYC  = NES_HALF_CYC
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       nes_data_p1,
    input  logic       nes_data_p2,
    output logic       nes_latch,
    output logic       nes_clk,
    output logic [7:0] buttons_p1,
    output logic [7:0] buttons_p2,
    output logic       valid,
    output logic       busy
);

    localparam int CW = nes_cnt_width(LATCH_CYC, HALF_CYC);
    localparam logic [CW-1:0] LATCH_LOAD = CW'(LATCH_CYC - 1);
    localparam logic [CW-1:0] HALF_LOAD  = CW'(HALF_CYC - 1);

    // state is kept as a named signal so checkers can bind to it directly
    nes_state_t    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]    idx, idx_nxt;
    logic [7:0]    sr_p1, sr_p2;
    logic          sync_p1, sync_p2;
    logic          shift_en;

    nes_input_sync u_sync_p1 (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (nes_data_p1),
        .dout (sync_p1)
    );

    nes_input_sync u_sync_p2 (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (nes_data_p2),
        .dout (sync_p2)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        shift_en  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = LATCH;
                    cnt_nxt   = LATCH_LOAD;
                    idx_nxt   = 3'd0;
                end
            end
            LATCH: begin
                if (cnt == '0) begin
                    state_nxt = LOW;
                    cnt_nxt   = HALF_LOAD;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            LOW: begin
                // sample at the very end of the low half, when the pad output has settled longest
                if (cnt == '0) begin
                    shift_en  = 1'b1;
                    state_nxt = HIGH;
                    cnt_nxt   = HALF_LOAD;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            HIGH: begin
                if (cnt == '0) begin
                    if (idx == 3'd7) begin
                        state_nxt = DONE;
                    end else begin
                        idx_nxt   = idx + 1'b1;
                        state_nxt = LOW;
                        cnt_nxt   = HALF_LOAD;
                    end
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they change on the same
    // edge as the state itself and never glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= 3'd0;
            sr_p1      <= 8'h00;
            sr_p2      <= 8'h00;
            nes_latch  <= 1'b0;
            nes_clk    <= 1'b0;
            buttons_p1 <= 8'h00;
            buttons_p2 <= 8'h00;
            valid      <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            idx       <= idx_nxt;
            nes_latch <= (state_nxt == LATCH);
            nes_clk   <= (state_nxt == HIGH);
            valid     <= (state_nxt == DONE);
            busy      <= (state_nxt == LATCH) || (state_nxt == LOW) || (state_nxt == HIGH);
            if (shift_en) begin
                sr_p1[idx] <= ~sync_p1;
                sr_p2[idx] <= ~sync_p2;
            end
            if (state_nxt == DONE) begin
                buttons_p1 <= sr_p1;
                buttons_p2 <= sr_p2;
            end
        end
    end

endmodule
